// File: rtl/spi_dac_pkg.sv
// Shared encodings for the SPI DAC transmit path: FSM state and bit-counter opcodes.
package spi_dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef logic [1:0] opc_t;

  localparam opc_t OPC_HOLD = 2'b00;
  localparam opc_t OPC_INC  = 2'b01;
  localparam opc_t OPC_CLR  = 2'b10;

endpackage

// File: rtl/spi_bit_cnt.sv
// Saturating bit counter for the SPI frame; flag_o marks DataWidth bits sent.
// Opcode takes effect on the next clock edge; no backpressure.
module spi_bit_cnt
  import spi_dac_pkg::*;
#(
  parameter int DataWidth = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  opc_t opc_i,
  output logic flag_o
);

  localparam int CntW = $clog2(DataWidth + 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else begin
      case (opc_i)
        OPC_INC: if (cnt != CntW'(DataWidth)) cnt <= cnt + CntW'(1);
        OPC_CLR: cnt <= '0;
        default: cnt <= cnt;
      endcase
    end
  end

  assign flag_o = (cnt == CntW'(DataWidth));

endmodule

// File: rtl/spi_dac_tx.sv
// SPI mode-0 master transmit stage for the DAC: one code per start/ready handshake, MSB first.
// Frame occupies 2*CsSetup + 2*ClkDiv*DataWidth + 1 cycles; ready_o low for the whole frame.
module spi_dac_tx
  import spi_dac_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int ClkDiv    = 4,
  parameter int CsSetup   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic                 sclk_o,
  output logic                 cs_no,
  output logic                 mosi_o
);

  // Single-value counters still need one bit of storage.
  localparam int DivW = (ClkDiv  > 1) ? $clog2(ClkDiv)  : 1;
  localparam int PhW  = (CsSetup > 1) ? $clog2(CsSetup) : 1;

  state_e               state, state_nxt;
  logic [DivW-1:0]      div_cnt, div_nxt;
  logic [PhW-1:0]       ph_cnt, ph_nxt;
  logic [DataWidth-1:0] sreg, sreg_nxt;
  logic                 sclk_nxt, mosi_nxt, cs_nxt, ready_nxt, done_nxt;
  logic                 div_wrap, ph_end, bits_done;
  opc_t                 opc;

  spi_bit_cnt #(
    .DataWidth(DataWidth)
  ) u_bit_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .opc_i (opc),
    .flag_o(bits_done)
  );

  assign div_wrap = (div_cnt == DivW'(ClkDiv - 1));
  assign ph_end   = (ph_cnt == PhW'(CsSetup - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      ph_cnt  <= '0;
      sreg    <= '0;
      sclk_o  <= 1'b0;
      mosi_o  <= 1'b0;
      cs_no   <= 1'b1;
      ready_o <= 1'b1;
      done_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      ph_cnt  <= ph_nxt;
      sreg    <= sreg_nxt;
      sclk_o  <= sclk_nxt;
      mosi_o  <= mosi_nxt;
      cs_no   <= cs_nxt;
      ready_o <= ready_nxt;
      done_o  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    ph_nxt    = ph_cnt;
    sreg_nxt  = sreg;
    sclk_nxt  = sclk_o;
    mosi_nxt  = mosi_o;
    opc       = OPC_HOLD;

    case (state)
      ST_IDLE: begin
        if (start_i && ready_o) begin
          sreg_nxt  = data_i;
          mosi_nxt  = data_i[DataWidth-1];
          ph_nxt    = '0;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (ph_end) begin
          div_nxt   = '0;
          state_nxt = ST_SHIFT;
        end else begin
          ph_nxt = ph_cnt + PhW'(1);
        end
      end
      ST_SHIFT: begin
        if (div_wrap) begin
          div_nxt  = '0;
          sclk_nxt = ~sclk_o;
          if (!sclk_o) begin
            opc = OPC_INC;
          end else if (bits_done) begin
            // Fall after the last rise closes the frame without shifting.
            ph_nxt    = '0;
            state_nxt = ST_HOLD;
          end else begin
            sreg_nxt = {sreg[DataWidth-2:0], 1'b0};
            mosi_nxt = sreg[DataWidth-2];
          end
        end else begin
          div_nxt = div_cnt + DivW'(1);
        end
      end
      ST_HOLD: begin
        if (ph_end) begin
          mosi_nxt  = 1'b0;
          state_nxt = ST_DONE;
        end else begin
          ph_nxt = ph_cnt + PhW'(1);
        end
      end
      ST_DONE: begin
        opc       = OPC_CLR;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    cs_nxt    = !(state_nxt inside {ST_SETUP, ST_SHIFT, ST_HOLD});
    ready_nxt = (state_nxt == ST_IDLE);
    done_nxt  = (state_nxt == ST_DONE);
  end

endmodule
